// File: rtl/cpu_if_q.sv
// CPU-to-cache request queue: buffers CPU read/write requests in a FIFO and
// issues them one at a time to the cache with a level/ack handshake and optional timeout.
module cpu_if_q #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic [ADDR_W-1:0]            sys_addr,
    input  logic                         sys_wr,
    input  logic                         sys_rd,
    input  logic [DATA_W-1:0]            sys_wdata,
    input  logic [DATA_W/8-1:0]          sys_bval,
    output logic                         sys_ready,
    output logic [$clog2(DEPTH+1)-1:0]   q_level,
    output logic [DATA_W-1:0]            sys_rdata,
    output logic                         sys_ack,
    output logic                         sys_err,
    output logic [ADDR_W-1:0]            c_addr,
    output logic                         c_wr,
    output logic                         c_rd,
    output logic [DATA_W-1:0]            c_wdata,
    output logic [DATA_W/8-1:0]          c_bval,
    input  logic [DATA_W-1:0]            c_rdata,
    input  logic                         c_ack
);

    localparam int unsigned BW = DATA_W / 8;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef struct packed {
        logic              rd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BW-1:0]     bval;
    } req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RESP
    } state_t;

    req_t          mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push, pop, timed_out;
    req_t          head;

    state_t            state_q;
    logic [TW-1:0]     timer_q;
    logic              c_rd_q, c_wr_q;
    logic [ADDR_W-1:0] c_addr_q;
    logic [DATA_W-1:0] c_wdata_q;
    logic [BW-1:0]     c_bval_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ack_q, err_q;

    assign sys_ready = (level_q != LW'(DEPTH));
    assign q_level   = level_q;
    assign head      = mem_q[rd_ptr_q];
    assign timed_out = (TIMEOUT != 0) && (timer_q == TLAST);

    always_comb begin
        push     = sys_ready && (sys_rd ^ sys_wr);
        pop      = (state_q == ST_IDLE) && (level_q != '0);
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push) - LW'(pop);
    end

    // Storage is not reset; the pointers and level define which entries are live.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= req_t'{rd: sys_rd, addr: sys_addr, wdata: sys_wdata, bval: sys_bval};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            c_rd_q    <= 1'b0;
            c_wr_q    <= 1'b0;
            c_addr_q  <= '0;
            c_wdata_q <= '0;
            c_bval_q  <= '0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        c_rd_q    <= head.rd;
                        c_wr_q    <= !head.rd;
                        c_addr_q  <= head.addr;
                        c_wdata_q <= head.wdata;
                        c_bval_q  <= head.bval;
                        timer_q   <= '0;
                        state_q   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (c_ack) begin
                        c_rd_q  <= 1'b0;
                        c_wr_q  <= 1'b0;
                        ack_q   <= 1'b1;
                        state_q <= ST_RESP;
                        if (c_rd_q) begin
                            rdata_q <= c_rdata;
                        end
                    end else if (timed_out) begin
                        c_rd_q  <= 1'b0;
                        c_wr_q  <= 1'b0;
                        ack_q   <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= ST_RESP;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_RESP: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign c_rd      = c_rd_q;
    assign c_wr      = c_wr_q;
    assign c_addr    = c_addr_q;
    assign c_wdata   = c_wdata_q;
    assign c_bval    = c_bval_q;
    assign sys_rdata = rdata_q;
    assign sys_ack   = ack_q;
    assign sys_err   = err_q;

endmodule

// File: tb/tb_cpu_if_q.sv
// Directed bench for cpu_if_q: table of per-cycle vectors on a no-timeout
// instance, plus hand-written timeout and reset-abandon sequences.
module tb_cpu_if_q;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: TIMEOUT=0
    logic        a_rst, a_rd, a_wr, a_cack, a_ready, a_ack, a_err, a_cwr, a_crd;
    logic [15:0] a_addr, a_caddr;
    logic [31:0] a_wdata, a_crdata, a_rdata, a_cwdata;
    logic [3:0]  a_bval, a_cbval;
    logic [2:0]  a_level;

    // Instance B: TIMEOUT=8
    logic        b_rst, b_rd, b_wr, b_cack, b_ready, b_ack, b_err, b_cwr, b_crd;
    logic [15:0] b_addr, b_caddr;
    logic [31:0] b_wdata, b_crdata, b_rdata, b_cwdata;
    logic [3:0]  b_bval, b_cbval;
    logic [2:0]  b_level;

    cpu_if_q #(.ADDR_W(16), .DATA_W(32), .DEPTH(4), .TIMEOUT(0)) u_a (
        .sys_clk(clk), .sys_rst(a_rst), .sys_addr(a_addr), .sys_wr(a_wr), .sys_rd(a_rd),
        .sys_wdata(a_wdata), .sys_bval(a_bval), .sys_ready(a_ready), .q_level(a_level),
        .sys_rdata(a_rdata), .sys_ack(a_ack), .sys_err(a_err), .c_addr(a_caddr),
        .c_wr(a_cwr), .c_rd(a_crd), .c_wdata(a_cwdata), .c_bval(a_cbval),
        .c_rdata(a_crdata), .c_ack(a_cack)
    );

    cpu_if_q #(.ADDR_W(16), .DATA_W(32), .DEPTH(4), .TIMEOUT(8)) u_b (
        .sys_clk(clk), .sys_rst(b_rst), .sys_addr(b_addr), .sys_wr(b_wr), .sys_rd(b_rd),
        .sys_wdata(b_wdata), .sys_bval(b_bval), .sys_ready(b_ready), .q_level(b_level),
        .sys_rdata(b_rdata), .sys_ack(b_ack), .sys_err(b_err), .c_addr(b_caddr),
        .c_wr(b_cwr), .c_rd(b_crd), .c_wdata(b_cwdata), .c_bval(b_cbval),
        .c_rdata(b_crdata), .c_ack(b_cack)
    );

    typedef struct packed {
        logic        rst;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bval;
        logic        ack;
        logic [31:0] crdata;
    } in_t;

    typedef struct packed {
        logic        ready;
        logic [2:0]  level;
        logic        ack;
        logic        err;
        logic        crd;
        logic        cwr;
        logic [15:0] caddr;
        logic [31:0] cwdata;
        logic [3:0]  cbval;
        logic [31:0] rdata;
    } out_t;

    typedef struct {
        string name;
        in_t   vin;
        out_t  vout;
    } vec_t;

    vec_t vecs[$];
    int   nvec = 0;
    int   nmis = 0;

    function automatic in_t mi(logic rst, logic rd, logic wr, logic [15:0] addr,
                               logic [31:0] wd, logic [3:0] be, logic ack, logic [31:0] crd);
        in_t r;
        r.rst = rst; r.rd = rd; r.wr = wr; r.addr = addr;
        r.wdata = wd; r.bval = be; r.ack = ack; r.crdata = crd;
        return r;
    endfunction

    function automatic out_t mo(logic rdy, logic [2:0] lvl, logic ack, logic err, logic crd,
                                logic cwr, logic [15:0] ca, logic [31:0] cwd, logic [3:0] cbe,
                                logic [31:0] rdata);
        out_t r;
        r.ready = rdy; r.level = lvl; r.ack = ack; r.err = err; r.crd = crd; r.cwr = cwr;
        r.caddr = ca; r.cwdata = cwd; r.cbval = cbe; r.rdata = rdata;
        return r;
    endfunction

    function automatic string fmt(out_t o);
        return $sformatf("rdy=%b lvl=%0d ack=%b err=%b c_rd=%b c_wr=%b c_addr=%h c_wdata=%h c_bval=%h rdata=%h",
                         o.ready, o.level, o.ack, o.err, o.crd, o.cwr, o.caddr, o.cwdata, o.cbval, o.rdata);
    endfunction

    function automatic out_t a_out();
        return mo(a_ready, a_level, a_ack, a_err, a_crd, a_cwr, a_caddr, a_cwdata, a_cbval, a_rdata);
    endfunction

    task automatic add(string n, in_t i, out_t o);
        vec_t v;
        v.name = n; v.vin = i; v.vout = o;
        vecs.push_back(v);
    endtask

    task automatic apply(in_t i);
        a_rst = i.rst; a_rd = i.rd; a_wr = i.wr; a_addr = i.addr;
        a_wdata = i.wdata; a_bval = i.bval; a_cack = i.ack; a_crdata = i.crdata;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(string n, out_t got, out_t exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %s; expected %s", n, fmt(got), fmt(exp));
        end
    endtask

    task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h", n, got, exp);
        end
    endtask

    task automatic bstep();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t  idle;
        out_t rst_o, o;
        logic [31:0] rd_prev;
        int   high;
        logic got_ack;
        int   lvl;

        idle  = mi(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        rst_o = mo(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 32'h0);

        b_rst = 1'b0; b_rd = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
        b_bval = '0; b_cack = 1'b0; b_crdata = '0;

        // Reset and release
        for (int k = 0; k < 3; k++) add("t1 reset", mi(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 32'h0), rst_o);
        add("t1 release", idle, rst_o);

        // Write with c_ack three cycles after c_wr rises
        add("t2 accept", mi(1'b1, 1'b0, 1'b1, 16'h010F, 32'h00012343, 4'b0010, 1'b0, 32'h0),
            mo(1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 32'h0));
        o = mo(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h010F, 32'h00012343, 4'b0010, 32'h0);
        add("t2 c_wr rise", idle, o);
        add("t2 c_wr hold1", idle, o);
        add("t2 c_wr hold2", idle, o);
        add("t2 c_ack", mi(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 32'h0),
            mo(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h010F, 32'h00012343, 4'b0010, 32'h0));
        o = mo(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h010F, 32'h00012343, 4'b0010, 32'h0);
        add("t2 ack clears", idle, o);
        add("c_ack in idle ignored", mi(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF), o);
        add("rd+wr dropped", mi(1'b1, 1'b1, 1'b1, 16'h5555, 32'h55555555, 4'hF, 1'b0, 32'h0), o);
        add("no issue after drop", idle, o);

        // Read returning data
        add("t3 accept", mi(1'b1, 1'b1, 1'b0, 16'h1234, 32'h0, 4'h0, 1'b0, 32'h0),
            mo(1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h010F, 32'h00012343, 4'b0010, 32'h0));
        add("t3 c_rd rise", idle, mo(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 32'h0, 4'h0, 32'h0));
        add("t3 c_ack", mi(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 32'h001234AB),
            mo(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 32'h0, 4'h0, 32'h001234AB));
        o = mo(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 32'h0, 4'h0, 32'h001234AB);
        add("t3 c_ack in resp ignored", mi(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 32'h0BADF00D), o);
        add("t3 rdata held", idle, o);

        // Fill the queue: write 0 in flight, 1..4 queued, 5 dropped
        for (int i = 0; i < 6; i++) begin
            lvl = (i > 4) ? 4 : i;
            if (i == 0)
                o = mo(1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 32'h0, 4'h0, 32'h001234AB);
            else
                o = mo(lvl != 4, 3'(lvl), 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 32'h100, 4'hF, 32'h001234AB);
            add($sformatf("t4 write %0d", i), mi(1'b1, 1'b0, 1'b1, 16'(i), 32'h100 + 32'(i), 4'hF, 1'b0, 32'h0), o);
        end
        // Drain in order
        for (int k = 0; k < 5; k++) begin
            lvl = 4 - k;
            add($sformatf("t4 ack %0d", k), mi(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 32'h0),
                mo(lvl != 4, 3'(lvl), 1'b1, 1'b0, 1'b0, 1'b0, 16'(k), 32'h100 + 32'(k), 4'hF, 32'h001234AB));
            add($sformatf("t4 resp %0d", k), idle,
                mo(lvl != 4, 3'(lvl), 1'b0, 1'b0, 1'b0, 1'b0, 16'(k), 32'h100 + 32'(k), 4'hF, 32'h001234AB));
            if (k < 4)
                add($sformatf("t4 issue %0d", k + 1), idle,
                    mo(1'b1, 3'(lvl - 1), 1'b0, 1'b0, 1'b0, 1'b1, 16'(k + 1), 32'h100 + 32'(k + 1), 4'hF, 32'h001234AB));
        end
        add("t4 queue drained", idle, mo(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4, 32'h104, 4'hF, 32'h001234AB));

        foreach (vecs[n]) begin
            apply(vecs[n].vin);
            chk_out(vecs[n].name, a_out(), vecs[n].vout);
        end

        // Reset while a read is in flight and two are queued, then a stray c_ack
        apply(mi(1'b1, 1'b1, 1'b0, 16'h00A0, 32'h0, 4'h0, 1'b0, 32'h0));
        apply(mi(1'b1, 1'b1, 1'b0, 16'h00A1, 32'h0, 4'h0, 1'b0, 32'h0));
        apply(mi(1'b1, 1'b1, 1'b0, 16'h00A2, 32'h0, 4'h0, 1'b0, 32'h0));
        chk("t6 setup c_rd/level", {a_crd, a_level, a_caddr}, {1'b1, 3'd2, 16'h00A0});
        apply(mi(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 32'h0));
        chk_out("t6 reset state", a_out(), rst_o);
        for (int k = 0; k < 4; k++) begin
            apply(mi(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 32'h12345678));
            chk_out($sformatf("t6 stray c_ack %0d", k), a_out(), rst_o);
        end

        // Timeout instance
        bstep();
        chk("t5 reset state", {b_ready, b_level, b_ack, b_err, b_crd, b_cwr, b_rdata},
            {1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
        b_rst = 1'b1;
        b_rd = 1'b1; b_addr = 16'h0042;
        bstep();
        b_rd = 1'b0;
        bstep();
        chk("t5 ref c_rd", {b_crd, b_caddr}, {1'b1, 16'h0042});
        b_cack = 1'b1; b_crdata = 32'hCAFEF00D;
        bstep();
        b_cack = 1'b0;
        chk("t5 ref read resp", {b_ack, b_err, b_rdata}, {1'b1, 1'b0, 32'hCAFEF00D});
        bstep();
        rd_prev = 32'hCAFEF00D;

        b_rd = 1'b1; b_addr = 16'h0043; b_crdata = 32'h11111111;
        bstep();
        b_rd = 1'b0;
        high = 0;
        got_ack = 1'b0;
        for (int k = 0; k < 20 && !got_ack; k++) begin
            bstep();
            if (b_crd) high++;
            if (b_ack) begin
                got_ack = 1'b1;
                chk("t5 timeout resp", {b_err, b_crd, b_rdata}, {1'b1, 1'b0, rd_prev});
            end
        end
        chk("t5 ack seen", 64'(got_ack), 64'd1);
        chk("t5 c_rd high cycles", 64'(high), 64'd8);
        bstep();
        chk("t5 ack/err clear", {b_ack, b_err, b_level}, {1'b0, 1'b0, 3'd0});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
